qeciphy_tx_width_conv: RTL and testbench

Parametrised TX serialiser that splits `RATIO`-beat wide words from the link layer into a continuous `OUT_W`-bit stream for the transceiver, one beat per clock. Adds a valid/ready handshake with a one-word buffer and automatic idle-frame insertion when no word is available. It generates per-byte K-character flags for frame-alignment words (FAW). It sits between the TX framer and the transceiver TX data port, and replaces the fixed 64b-to-32b converter.

---
 rtl/qeciphy_pkg.sv | 12 +
 rtl/qeciphy_tx_skid_buf.sv | 59 +++++
 rtl/qeciphy_tx_width_conv.sv | 106 ++++++++++
 tb/tb_qeciphy_tx_width_conv.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qeciphy_pkg.sv
// Shared constants and helpers for the QEC PHY transmit path.
package qeciphy_pkg;

    // K-flag pattern for the first beat of a frame-alignment word: only byte 0 is a K character.
    localparam logic [63:0] FAW_KFLAG_PATTERN = 64'h1;

    // The serialiser only supports power-of-two beat counts that the beat counter can wrap cleanly.
    function automatic bit isLegalRatio(input int unsigned ratio);
        return (ratio == 2) || (ratio == 4) || (ratio == 8);
    endfunction

endpackage

// File: rtl/qeciphy_tx_skid_buf.sv
// One-entry skid buffer with bypass feeding the TX frame register.
// The frame register may only take a new word at a frame boundary; this buffer
// absorbs a word that arrives mid-frame and hands the oldest word over at the boundary.
module qeciphy_tx_skid_buf
    import qeciphy_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              boundary_i,
    input  logic [DATA_W-1:0] s_tdata_i,
    input  logic              s_tisfaw_i,
    input  logic              s_tvalid_i,
    output logic              s_tready_o,
    output logic              load_valid_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              load_isfaw_o
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;
    logic              r_isFaw;
    logic              w_ready;
    logic              w_xfer;

    // Ready is open whenever the slot is free or the slot drains into the frame this cycle;
    // the word offered to the frame is the buffered one first, otherwise the incoming one.
    always_comb begin
        w_ready      = ~rst_i & (~r_full | boundary_i);
        w_xfer       = s_tvalid_i & w_ready;
        load_valid_o = r_full | w_xfer;
        load_data_o  = r_full ? r_data  : s_tdata_i;
        load_isfaw_o = r_full ? r_isFaw : s_tisfaw_i;
    end

    assign s_tready_o = w_ready;

    // Capture a word unless it bypasses straight into an empty-buffer boundary load;
    // at a boundary the slot drains and refills in the same edge when a transfer occurs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_full  <= 1'b0;
            r_data  <= '0;
            r_isFaw <= 1'b0;
        end else begin
            if (w_xfer && (r_full || !boundary_i)) begin
                r_data  <= s_tdata_i;
                r_isFaw <= s_tisfaw_i;
            end
            if (boundary_i) begin
                r_full <= r_full & w_xfer;
            end else if (w_xfer) begin
                r_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/qeciphy_tx_width_conv.sv
// TX width converter: serialises RATIO-beat words into an OUT_W-bit stream,
// one beat per clock, inserting idle FAW frames whenever no word is ready.
module qeciphy_tx_width_conv
    import qeciphy_pkg::*;
#(
    parameter  int unsigned          OUT_W     = 32,
    parameter  int unsigned          RATIO     = 2,
    localparam int unsigned          IN_W      = OUT_W * RATIO,
    parameter  logic [IN_W-1:0]      IDLE_DATA = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IN_W-1:0]      s_tdata_i,
    input  logic                 s_tisfaw_i,
    input  logic                 s_tvalid_i,
    output logic                 s_tready_o,
    output logic [OUT_W-1:0]     tdata_o,
    output logic [OUT_W/8-1:0]   tcharisk_o,
    output logic                 frame_start_o,
    output logic                 underflow_o
);

    localparam int unsigned     BEAT_W = $clog2(RATIO);
    localparam int unsigned     K_W    = OUT_W / 8;
    localparam logic [K_W-1:0]  K_FAW  = FAW_KFLAG_PATTERN[K_W-1:0];

    if (!isLegalRatio(RATIO)) begin : g_illegalRatio
        $error("qeciphy_tx_width_conv: RATIO=%0d is illegal, must be 2, 4 or 8", RATIO);
    end

    logic [BEAT_W-1:0] r_beat;
    logic [IN_W-1:0]   r_frameData;
    logic              r_frameIsFaw;
    logic [OUT_W-1:0]  r_tdata;
    logic [K_W-1:0]    r_tcharisk;
    logic              r_frameStart;
    logic              r_underflow;

    logic              w_boundary;
    logic              w_loadValid;
    logic [IN_W-1:0]   w_loadData;
    logic              w_loadIsFaw;
    logic [OUT_W-1:0]  w_frameBeats [RATIO];

    assign w_boundary = (r_beat == BEAT_W'(RATIO - 1));

    for (genvar g = 0; g < RATIO; g++) begin : g_beatSlice
        assign w_frameBeats[g] = r_frameData[g*OUT_W +: OUT_W];
    end

    qeciphy_tx_skid_buf #(
        .DATA_W (IN_W)
    ) u_skidBuf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .boundary_i   (w_boundary),
        .s_tdata_i    (s_tdata_i),
        .s_tisfaw_i   (s_tisfaw_i),
        .s_tvalid_i   (s_tvalid_i),
        .s_tready_o   (s_tready_o),
        .load_valid_o (w_loadValid),
        .load_data_o  (w_loadData),
        .load_isfaw_o (w_loadIsFaw)
    );

    // Beat counter free-runs; at each boundary the frame takes the next word or an idle FAW.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_beat       <= '0;
            r_frameData  <= IDLE_DATA;
            r_frameIsFaw <= 1'b1;
        end else begin
            r_beat <= w_boundary ? '0 : r_beat + 1'b1;
            if (w_boundary) begin
                if (w_loadValid) begin
                    r_frameData  <= w_loadData;
                    r_frameIsFaw <= w_loadIsFaw;
                end else begin
                    r_frameData  <= IDLE_DATA;
                    r_frameIsFaw <= 1'b1;
                end
            end
        end
    end

    // Output stage registers the selected beat plus its frame-start, K and underflow markers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tdata      <= '0;
            r_tcharisk   <= '0;
            r_frameStart <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_tdata      <= w_frameBeats[r_beat];
            r_frameStart <= (r_beat == '0);
            r_tcharisk   <= ((r_beat == '0) && r_frameIsFaw) ? K_FAW : '0;
            r_underflow  <= w_boundary & ~w_loadValid;
        end
    end

    assign tdata_o       = r_tdata;
    assign tcharisk_o    = r_tcharisk;
    assign frame_start_o = r_frameStart;
    assign underflow_o   = r_underflow;

endmodule

// File: tb/tb_qeciphy_tx_width_conv.sv
// Testbench for qeciphy_tx_width_conv: directed vectors on a RATIO=2 and a RATIO=4 instance,
// plus a long backpressure run on the RATIO=2 instance checked by an in-order scoreboard.
module tb_qeciphy_tx_width_conv;

    localparam logic [63:0] IDLE2 = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [31:0] I0    = 32'h0F0F_F0F0;
    localparam logic [31:0] I1    = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // RATIO=2 instance signals
    logic        rst2 = 1'b1;
    logic [63:0] d2   = '0;
    logic        f2   = 1'b0;
    logic        v2   = 1'b0;
    logic        r2;
    logic [31:0] td2;
    logic        k2;
    logic        fs2;
    logic        uf2;

    // RATIO=4 instance signals
    logic         rst4 = 1'b1;
    logic [127:0] d4   = '0;
    logic         f4   = 1'b0;
    logic         v4   = 1'b0;
    logic         r4;
    logic [31:0]  td4;
    logic [3:0]   k4;
    logic         fs4;
    logic         uf4;

    qeciphy_tx_width_conv #(
        .OUT_W     (32),
        .RATIO     (2),
        .IDLE_DATA (IDLE2)
    ) dut2 (
        .clk_i         (clk),
        .rst_i         (rst2),
        .s_tdata_i     (d2),
        .s_tisfaw_i    (f2),
        .s_tvalid_i    (v2),
        .s_tready_o    (r2),
        .tdata_o       (td2),
        .tcharisk_o    (k2),
        .frame_start_o (fs2),
        .underflow_o   (uf2)
    );

    qeciphy_tx_width_conv #(
        .OUT_W (32),
        .RATIO (4)
    ) dut4 (
        .clk_i         (clk),
        .rst_i         (rst4),
        .s_tdata_i     (d4),
        .s_tisfaw_i    (f4),
        .s_tvalid_i    (v4),
        .s_tready_o    (r4),
        .tdata_o       (td4),
        .tcharisk_o    (k4),
        .frame_start_o (fs4),
        .underflow_o   (uf4)
    );

    typedef struct {
        logic         rst;
        logic         valid;
        logic [127:0] data;
        logic         faw;
        logic         expReady;
        logic [31:0]  expData;
        logic         expFs;
        logic [3:0]   expK;
        logic         expUf;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        faw;
        int          accEdge;
    } word_t;

    int    checksTotal  = 0;
    int    checksPassed = 0;
    int    cyc          = 0;
    int    rxCount      = 0;
    logic  monOn        = 1'b0;
    logic  haveBeat0    = 1'b0;
    logic  beat0IsIdle  = 1'b0;
    logic [31:0] beat0Data;
    logic        beat0K;
    word_t expQ[$];
    vec_t  tbl2[$];
    vec_t  tbl4[$];

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checksTotal++;
        if (obs === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic rst, input logic valid, input logic [127:0] data,
                                   input logic faw, input logic expReady, input logic [31:0] expData,
                                   input logic expFs, input logic [3:0] expK, input logic expUf);
        vec_t v;
        v.rst = rst; v.valid = valid; v.data = data; v.faw = faw; v.expReady = expReady;
        v.expData = expData; v.expFs = expFs; v.expK = expK; v.expUf = expUf;
        return v;
    endfunction

    // Drive one cycle of inputs at a negedge, check ready, then check the outputs after the next edge.
    task automatic applyStimulus(input int sel, input int idx, input vec_t v);
        if (sel == 2) begin
            rst2 = v.rst; v2 = v.valid; d2 = v.data[63:0]; f2 = v.faw;
        end else begin
            rst4 = v.rst; v4 = v.valid; d4 = v.data; f4 = v.faw;
        end
        #1;
        checkOutput($sformatf("r%0d.%0d ready", sel, idx), (sel == 2) ? r2 : r4, v.expReady);
        @(negedge clk);
        checkOutput($sformatf("r%0d.%0d tdata", sel, idx), (sel == 2) ? td2 : td4, v.expData);
        checkOutput($sformatf("r%0d.%0d fs", sel, idx), (sel == 2) ? fs2 : fs4, v.expFs);
        checkOutput($sformatf("r%0d.%0d k", sel, idx), (sel == 2) ? {3'b000, k2} : k4, v.expK);
        checkOutput($sformatf("r%0d.%0d uf", sel, idx), (sel == 2) ? uf2 : uf4, v.expUf);
    endtask

    // Edge counter used to timestamp accepted words for the idle-gap check.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: reassembles RATIO=2 frames and matches real words in order.
    always @(negedge clk) begin
        if (monOn) begin
            if (fs2) begin
                haveBeat0   <= 1'b1;
                beat0Data   <= td2;
                beat0K      <= k2;
                beat0IsIdle <= k2 && (td2 == IDLE2[31:0]);
                if (k2 && (td2 == IDLE2[31:0])) begin
                    checkOutput("bpIdleGap", (expQ.size() == 0) || (expQ[0].accEdge >= cyc), 1'b1);
                end
            end else if (haveBeat0) begin
                haveBeat0 <= 1'b0;
                if (beat0IsIdle) begin
                    checkOutput("bpIdleBeat1", {k2, td2}, {1'b0, IDLE2[63:32]});
                end else begin
                    checkOutput("bpQueueNonEmpty", expQ.size() > 0, 1'b1);
                    if (expQ.size() > 0) begin
                        checkOutput($sformatf("bpWord%0d", rxCount), {td2, beat0Data}, expQ[0].data);
                        checkOutput($sformatf("bpK%0d", rxCount), {k2, beat0K}, {1'b0, expQ[0].faw});
                        void'(expQ.pop_front());
                        rxCount++;
                    end
                end
            end
        end
    end

    // Hard stop if anything stalls the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        // RATIO=2: reset, idle stream, back-to-back words, bypass FAW, reset with a full buffer
        tbl2.push_back(mkVec(1, 0, '0, 0, 0, 32'h0, 0, 4'h0, 0));
        tbl2.push_back(mkVec(1, 0, '0, 0, 0, 32'h0, 0, 4'h0, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, I0, 1, 4'h1, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, I1, 0, 4'h0, 1));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, I0, 1, 4'h1, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, I1, 0, 4'h0, 1));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, I0, 1, 4'h1, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, I1, 0, 4'h0, 1));
        tbl2.push_back(mkVec(0, 1, 128'h1111_1111_2222_2222, 0, 1, I0, 1, 4'h1, 0));
        tbl2.push_back(mkVec(0, 1, 128'h3333_3333_4444_4444, 0, 1, I1, 0, 4'h0, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 0, 32'h2222_2222, 1, 4'h0, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, 32'h1111_1111, 0, 4'h0, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, 32'h4444_4444, 1, 4'h0, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, 32'h3333_3333, 0, 4'h0, 1));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, I0, 1, 4'h1, 0));
        tbl2.push_back(mkVec(0, 1, 128'h5555_5555_6666_6666, 1, 1, I1, 0, 4'h0, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, 32'h6666_6666, 1, 4'h1, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, 32'h5555_5555, 0, 4'h0, 1));
        tbl2.push_back(mkVec(0, 1, 128'hDEAD_BEEF_CAFE_F00D, 0, 1, I0, 1, 4'h1, 0));
        tbl2.push_back(mkVec(1, 0, '0, 0, 0, 32'h0, 0, 4'h0, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, I0, 1, 4'h1, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, I1, 0, 4'h0, 1));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, I0, 1, 4'h1, 0));
        tbl2.push_back(mkVec(0, 0, '0, 0, 1, I1, 0, 4'h0, 1));

        // RATIO=4: one FAW word offered mid-frame, emitted at the next boundary
        tbl4.push_back(mkVec(1, 0, '0, 0, 0, 32'h0, 0, 4'h0, 0));
        tbl4.push_back(mkVec(0, 0, '0, 0, 1, 32'h0, 1, 4'h1, 0));
        tbl4.push_back(mkVec(0, 1, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 1, 1, 32'h0, 0, 4'h0, 0));
        tbl4.push_back(mkVec(0, 0, '0, 0, 0, 32'h0, 0, 4'h0, 0));
        tbl4.push_back(mkVec(0, 0, '0, 0, 1, 32'h0, 0, 4'h0, 0));
        tbl4.push_back(mkVec(0, 0, '0, 0, 1, 32'h1111_1111, 1, 4'h1, 0));
        tbl4.push_back(mkVec(0, 0, '0, 0, 1, 32'h2222_2222, 0, 4'h0, 0));
        tbl4.push_back(mkVec(0, 0, '0, 0, 1, 32'h3333_3333, 0, 4'h0, 0));
        tbl4.push_back(mkVec(0, 0, '0, 0, 1, 32'h4444_4444, 0, 4'h0, 1));
        tbl4.push_back(mkVec(0, 0, '0, 0, 1, 32'h0, 1, 4'h1, 0));

        @(negedge clk);
        $display("[TB] RATIO=2 directed vectors");
        for (int i = 0; i < tbl2.size(); i++) begin
            applyStimulus(2, i, tbl2[i]);
        end

        $display("[TB] RATIO=2 backpressure run");
        monOn = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int   gap;
            int   waits;
            logic accepted;
            gap = (((i * 7) % 11) < 3) ? ((i * 3) % 4) : 0;
            v2 = 1'b0;
            repeat (gap) @(negedge clk);
            v2 = 1'b1;
            d2 = {16'hB0B0, 16'(i), 16'hA0A0, 16'(i)};
            f2 = ((i % 4) == 1);
            accepted = 1'b0;
            waits = 0;
            while (!accepted && (waits <= 16)) begin
                #1;
                if (r2) begin
                    accepted = 1'b1;
                    expQ.push_back('{data: d2, faw: f2, accEdge: cyc + 1});
                end
                @(negedge clk);
                waits++;
            end
            if (!accepted) begin
                checkOutput($sformatf("bpAcceptTimeout%0d", i), waits, 0);
            end
        end
        v2 = 1'b0;
        repeat (12) @(negedge clk);
        monOn = 1'b0;
        checkOutput("bpRxCount", rxCount, 1000);
        checkOutput("bpQueueDrained", expQ.size(), 0);

        $display("[TB] RATIO=4 directed vectors");
        for (int i = 0; i < tbl4.size(); i++) begin
            applyStimulus(4, i, tbl4[i]);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
